// File: rtl/if_pkg.sv
// Shared definitions for the IF stage fetch queue: NOP encoding, default width
// and the packed fetch-entry layout {pc, instr, pred_taken}.
package if_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int PC_W    = XLEN_DEFAULT;
  localparam int INSTR_W = XLEN_DEFAULT;
  localparam int PRED_W  = 1;
  localparam int ENTRY_W_DEFAULT = PC_W + INSTR_W + PRED_W;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               pred_taken;
  } fetch_entry_t;

  // Width of a packed entry for an arbitrary XLEN.
  function automatic int entry_w(input int xlen);
    return 2 * xlen + 1;
  endfunction

endpackage

// File: rtl/if_fetch_queue_mem.sv
// Fetch queue storage: DEPTH x W register file, one write port, one
// asynchronous read port, no reset on data.
module if_fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 65,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// IF-to-ID decoupling queue with EX-redirect flush. Defining
// IF_FETCH_QUEUE_BYPASS_EN adds a zero-latency path when the queue is empty.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_instr,
  input  logic                   in_pred_taken,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_instr,
  output logic                   out_pred_taken,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = entry_w(XLEN);

  // Handshakes: a transfer happens on a rising edge where valid && ready is
  // high and flush is low; in_ready depends only on registered occupancy.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty, full;
  logic          push, pop, wr_en, rd_adv;
  logic [EW-1:0] rd_data, wr_data;
  logic [XLEN-1:0] sel_pc, sel_instr;
  logic          sel_pred;

  if_fetch_queue_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign wr_data = {in_pc, in_instr, in_pred_taken};

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    in_ready  = !full;

    out_valid = !empty && !flush;
    sel_pc    = rd_data[EW-1 -: XLEN];
    sel_instr = rd_data[XLEN:1];
    sel_pred  = rd_data[0];
`ifdef IF_FETCH_QUEUE_BYPASS_EN
    if (empty && in_valid && !flush) begin
      out_valid = 1'b1;
      sel_pc    = in_pc;
      sel_instr = in_instr;
      sel_pred  = in_pred_taken;
    end
`endif

    // Invalid head is presented as a NOP so ID never decodes stale storage.
    out_pc         = out_valid ? sel_pc    : '0;
    out_instr      = out_valid ? sel_instr : XLEN'(NOP_INSTR);
    out_pred_taken = out_valid ? sel_pred  : 1'b0;

    push   = in_valid && in_ready && !flush;
    pop    = out_valid && out_ready;
    wr_en  = push;
    rd_adv = pop;
`ifdef IF_FETCH_QUEUE_BYPASS_EN
    // A pop while empty consumes the bypassed entry, so storage is untouched.
    if (empty) begin
      rd_adv = 1'b0;
      if (out_ready) wr_en = 1'b0;
    end
`endif

    wr_ptr_d = wr_en  ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_adv ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(rd_adv);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue (DEPTH=4, XLEN=32); the
// bypass expectations follow IF_FETCH_QUEUE_BYPASS_EN.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int SW    = 2 * XLEN + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic [XLEN-1:0] in_pc = '0;
  logic [XLEN-1:0] in_instr = '0;
  logic            in_pred_taken = 1'b0;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_pred_taken;
  logic            out_ready = 1'b0;
  logic [2:0]      count;

  int total = 0;
  int bad   = 0;
  logic [SW-1:0] exp_q[$];

  if_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .in_pred_taken  (in_pred_taken),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_pred_taken (out_pred_taken),
    .out_ready      (out_ready),
    .count          (count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  function automatic logic pred_of(input logic [XLEN-1:0] pc);
    return pc[3];
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [XLEN-1:0] pc);
    in_valid      = v;
    in_pc         = pc;
    in_instr      = instr_of(pc);
    in_pred_taken = pred_of(pc);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, SW'(out_valid), SW'(0));
    check({tag, "_instr"}, SW'(out_instr), SW'(32'h13));
    check({tag, "_pc"},    SW'(out_pc),    SW'(0));
    check({tag, "_pred"},  SW'(out_pred_taken), SW'(0));
  endtask

  task automatic check_head(input string tag, input logic [XLEN-1:0] pc);
    check({tag, "_valid"}, SW'(out_valid), SW'(1));
    check({tag, "_entry"}, {out_pc, out_instr, out_pred_taken},
          {pc, instr_of(pc), pred_of(pc)});
  endtask

  // Drain with out_ready=1 until empty, bounded.
  task automatic drain(input string tag);
    int n;
    out_ready = 1'b1;
    drive_in(1'b0, '0);
    n = 0;
    while (count != 0 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, SW'(count), SW'(0));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [XLEN-1:0] pc;
    logic [SW-1:0]   exp_e;

    // Reset state
    #2;
    check_empty("rst");
    check("rst_in_ready", SW'(in_ready), SW'(1));
    check("rst_count", SW'(count), SW'(0));
    tick();
    rst = 1'b1;
    tick();

    // Fill with out_ready low
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, XLEN'(4 * i));
      tick();
      check($sformatf("fill_count%0d", i), SW'(count), SW'(i + 1));
      check_head($sformatf("fill_head%0d", i), 32'h0);
    end
    check("full_in_ready", SW'(in_ready), SW'(0));

    // Full boundary: pop happens, push of 0x10 is blocked
    drive_in(1'b1, 32'h10);
    out_ready = 1'b1;
    @(negedge clk);
    check_head("full_pop_head", 32'h0);
    check("full_in_ready_before", SW'(in_ready), SW'(0));
    tick();
    check("full_count_after", SW'(count), SW'(3));
    check("full_in_ready_after", SW'(in_ready), SW'(1));

    // Drain remaining in order
    drive_in(1'b0, '0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check_head($sformatf("drain%0d", i), XLEN'(4 * i));
      tick();
    end
    @(negedge clk);
    check_empty("drained");
    check("drained_count", SW'(count), SW'(0));
    out_ready = 1'b0;
    tick();

    // Streaming: prefill 2, then push+pop for 20 cycles
    for (int i = 0; i < 2; i++) begin
      pc = 32'h1000 + XLEN'(4 * i);
      drive_in(1'b1, pc);
      exp_q.push_back({pc, instr_of(pc), pred_of(pc)});
      tick();
    end
    out_ready = 1'b1;
    for (int k = 2; k < 22; k++) begin
      pc = 32'h1000 + XLEN'(4 * k);
      drive_in(1'b1, pc);
      @(negedge clk);
      exp_q.push_back({pc, instr_of(pc), pred_of(pc)});
      exp_e = exp_q.pop_front();
      check($sformatf("stream_valid%0d", k), SW'(out_valid), SW'(1));
      check($sformatf("stream_entry%0d", k), {out_pc, out_instr, out_pred_taken}, exp_e);
      tick();
      check($sformatf("stream_count%0d", k), SW'(count), SW'(2));
    end
    drive_in(1'b0, '0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_e = exp_q.pop_front();
      check("stream_tail", {out_pc, out_instr, out_pred_taken}, exp_e);
      tick();
    end
    check("stream_empty", SW'(count), SW'(0));
    out_ready = 1'b0;

    // Flush with a concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, 32'h80 + XLEN'(4 * i));
      tick();
    end
    check("pre_flush_count", SW'(count), SW'(3));
    drive_in(1'b1, 32'h200);
    out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_valid", SW'(out_valid), SW'(0));
    check("flush_in_ready", SW'(in_ready), SW'(1));
    tick();
    flush = 1'b0;
    drive_in(1'b0, '0);
    @(negedge clk);
    check("post_flush_count", SW'(count), SW'(0));
    check_empty("post_flush");
    out_ready = 1'b0;
    drive_in(1'b1, 32'h100);
    tick();
    drive_in(1'b0, '0);
    @(negedge clk);
    check_head("after_flush_head", 32'h100);
    check("after_flush_count", SW'(count), SW'(1));
    drain("flush");
    tick();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 2; i++) begin
      drive_in(1'b1, 32'h180 + XLEN'(4 * i));
      tick();
    end
    drive_in(1'b0, '0);
    check("pre_rst_count", SW'(count), SW'(2));
    #2 rst = 1'b0;
    #1;
    check("arst_valid", SW'(out_valid), SW'(0));
    check("arst_count", SW'(count), SW'(0));
    check("arst_in_ready", SW'(in_ready), SW'(1));
    check("arst_instr", SW'(out_instr), SW'(32'h13));
    tick();
    #2 rst = 1'b1;
    tick();
    drive_in(1'b1, 32'h300);
    tick();
    drive_in(1'b0, '0);
    @(negedge clk);
    check_head("post_rst_head", 32'h300);
    check("post_rst_count", SW'(count), SW'(1));
    drain("rst");
    tick();

    // Bypass behaviour on an empty queue
    drive_in(1'b1, 32'h40);
    in_pred_taken = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
`ifdef IF_FETCH_QUEUE_BYPASS_EN
    check("byp_valid", SW'(out_valid), SW'(1));
    check("byp_pc", SW'(out_pc), SW'(32'h40));
    check("byp_pred", SW'(out_pred_taken), SW'(1));
    tick();
    drive_in(1'b0, '0);
    @(negedge clk);
    check("byp_count", SW'(count), SW'(0));
    check("byp_after_valid", SW'(out_valid), SW'(0));
`else
    check("nobyp_valid", SW'(out_valid), SW'(0));
    check("nobyp_instr", SW'(out_instr), SW'(32'h13));
    tick();
    drive_in(1'b0, '0);
    @(negedge clk);
    check("nobyp_late_valid", SW'(out_valid), SW'(1));
    check("nobyp_late_pc", SW'(out_pc), SW'(32'h40));
    check("nobyp_late_pred", SW'(out_pred_taken), SW'(1));
    check("nobyp_count", SW'(count), SW'(1));
`endif
    drain("byp");

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Fetch-to-decode decoupling queue between the IF stage (PC register, branch target buffer (BTB) lookup, instruction memory) and the ID stage.
- Buffers up to DEPTH fetched entries. Each entry holds the PC, the instruction and the BTB predicted-taken bit.
- Lets IF keep fetching while ID is stalled, and back-pressures IF through `in_ready`, which feeds the IF `pc_en`.
- Flushes every entry when EX redirects the PC.

## Interface
- `DEPTH`, default 4: entry count; a power of two, 2 to 16.
- `XLEN`, default 32: PC and instruction width.
- `clk`  in  1: single clock; rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `flush`  in  1: EX redirect (`modify_pc_ex`); clears the queue.
- `in_valid`  in  1: IF presents a fetched entry.
- `in_pc`  in  XLEN: PC of the fetched instruction.
- `in_instr`  in  XLEN: fetched instruction.
- `in_pred_taken`  in  1: BTB predicted-taken bit.
- `in_ready`  out  1: queue accepts an entry; ANDed into IF `pc_en`.
- `out_valid`  out  1: head entry is valid for ID.
- `out_pc`  out  XLEN: head PC.
- `out_instr`  out  XLEN: head instruction; NOP when not valid.
- `out_pred_taken`  out  1: head predicted-taken bit; 0 when not valid.
- `out_ready`  in  1: ID consumes the head (the inverse of the hazard-unit stall).
- `count`  out  $clog2(DEPTH)+1: current occupancy.

## Operation
- **Push:** `in_valid && in_ready && !flush`. Writes the entry at `wr_ptr`, then increments `wr_ptr` modulo DEPTH.
- **Pop:** `out_valid && out_ready && !flush`. Increments `rd_ptr` modulo DEPTH.
- **Count update:**
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged.
  - Push and pop in the same cycle when full: cannot occur, because `in_ready` is low when full.
- **`in_ready`:** `count != DEPTH`. It is combinational from registered state only, with no dependence on `out_ready`, which avoids a loop through the hazard unit.
- **Head outputs:**
  - Read combinationally from the storage entry at `rd_ptr`.
  - When `count == 0`: `out_valid = 0`, `out_instr = NOP_INSTR` (32'h0000_0013), `out_pc = 0`, `out_pred_taken = 0`.
- **Flush (synchronous):**
  - On the next edge, `wr_ptr`, `rd_ptr` and `count` all become 0.
  - A push or pop presented in the flush cycle is discarded.
  - `out_valid` is forced to 0 combinationally during the flush cycle.
  - `in_ready` is not gated by flush.
- **Stored entries:** never modified after the write. No partial flush.
- **Reset (asynchronous, `rst` low):**
  - Pointers and `count` go to 0.
  - Storage contents are don't-care, but outputs are masked as for empty.
  - `out_valid = 0`, `in_ready = 1`, `count = 0`, `out_instr = NOP_INSTR`.
  - Reset asserted mid-operation drops all entries immediately.

## Timing
- Without bypass: an entry pushed at edge N is visible on `out_*` in the cycle after edge N. This is a one-cycle latency.
- Throughput: one push and one pop per cycle in steady state.
- Full queue with `out_ready = 1`: the pop frees a slot, but `in_ready` rises only in the following cycle. This is one bubble, by design.
- Empty queue with `out_ready = 1` and no bypass: ID sees `out_valid = 0` with NOP.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full versus empty is resolved by `count`, not by pointer comparison.
- Flush and reset have priority over push and pop. Reset has priority over flush.

## Configuration
- **`IF_FETCH_QUEUE_BYPASS_EN` defined:**
  - When `count == 0 && in_valid && !flush`, `out_*` are driven combinationally from `in_*` and `out_valid = 1` in the same cycle.
  - If `out_ready` is also 1, the entry is consumed without a write and the pointers are unchanged.
  - If `out_ready` is 0, the entry is written normally.
  - Latency is 0 when empty.
- **Not defined:** the bypass path is absent and latency is always 1 cycle.

## Structure
- Shared package `if_pkg` holds:
  - `NOP_INSTR`;
  - the XLEN default;
  - the fetch entry field widths and the packed entry layout `{pc, instr, pred_taken}`, 2·XLEN+1 bits.
- Sub-module `if_fetch_queue_mem`: DEPTH × (2·XLEN+1) register file with one write port and one asynchronous read port, no reset on data. The control, pointers, count and bypass logic stay in the top module.

## Test plan
- **Fill, then drain:** DEPTH=4, `out_ready = 0`, push PCs 0x0, 0x4, 0x8, 0xC.
  - After the 4th push: `count = 4`, `in_ready = 0`.
  - Then `out_ready = 1`: four pops in order 0x0 → 0xC, then `out_valid = 0` and `out_instr = 0x13`.
- **Streaming:** continuous push and pop for 20 cycles.
  - `count` stays constant.
  - Output PC sequence equals input order across ≥3 pointer wraps.
- **Flush:** push 3 entries, then assert `flush` together with `in_valid` and `out_ready`.
  - In the flush cycle, `out_valid = 0`.
  - Next cycle: `count = 0`, no entry delivered.
  - A push of PC 0x100 afterwards is the next output.
- **Asynchronous reset mid-stream:** drop `rst` between clock edges with `count = 2`.
  - Immediately: `out_valid = 0`, `count = 0`, `in_ready = 1`.
  - After release, the first push appears correctly.
- **Bypass** (`IF_FETCH_QUEUE_BYPASS_EN`): queue empty, `in_valid = 1`, `in_pc = 0x40`, `in_pred_taken = 1`, `out_ready = 1`.
  - Same cycle: `out_valid = 1`, `out_pc = 0x40`, `out_pred_taken = 1`.
  - `count` stays 0.
  - Without the macro, `out_pc = 0x40` appears one cycle later.
- **Full boundary:** queue full, `out_ready = 1`, `in_valid = 1`.
  - The pop occurs and the push is blocked.
  - Next cycle: `in_ready = 1` and `count = 3`.
